// File: rtl/peripheral_timer.sv
// Bus-mapped peripheral: reload timer with sticky overflow interrupt, LED and
// 7-segment output registers, and a read-only switch port.
module peripheral_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_W     = 8,
  parameter int          SW_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd,
  input  logic             wr,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  switch,
  output logic [11:0]      digi,
  output logic             irqout
);

  localparam int NREG = 6;

  logic             hit;
  logic [2:0]       idx;
  logic [NREG-1:0]  wr_sel;

  logic [31:0]      th_reg, th_next;
  logic [31:0]      tl_reg, tl_next;
  logic [2:0]       tcon_reg, tcon_next;
  logic [LED_W-1:0] led_reg, led_next;
  logic [11:0]      digi_reg, digi_next;

  logic             ovf;
  logic             ovf_set;

  // 32-byte window; the two words past DIGI decode as unmapped.
  assign hit = (addr[31:5] == BASE_ADDR[31:5]);
  assign idx = addr[4:2];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_wsel
      assign wr_sel[gi] = wr & hit & (idx == 3'(gi));
    end
  endgenerate

  // A CPU write to TL suppresses the overflow event on that edge.
  assign ovf     = tcon_reg[0] & (&tl_reg) & ~wr_sel[1];
  assign ovf_set = ovf & tcon_reg[1];

  always_comb begin
    th_next   = th_reg;
    tl_next   = tl_reg;
    tcon_next = tcon_reg;
    led_next  = led_reg;
    digi_next = digi_reg;

    if (wr_sel[0]) th_next = wdata;

    if (wr_sel[1])        tl_next = wdata;
    else if (ovf)         tl_next = th_reg;
    else if (tcon_reg[0]) tl_next = tl_reg + 32'd1;

    // Status is OR-ed in so an overflow coinciding with a handler write is kept.
    if (wr_sel[2])    tcon_next = {wdata[2] | ovf_set, wdata[1:0]};
    else if (ovf_set) tcon_next[2] = 1'b1;

    if (wr_sel[3]) led_next  = wdata[LED_W-1:0];
    if (wr_sel[5]) digi_next = wdata[11:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_reg   <= '0;
      tl_reg   <= '0;
      tcon_reg <= '0;
      led_reg  <= '0;
      digi_reg <= '0;
    end else begin
      th_reg   <= th_next;
      tl_reg   <= tl_next;
      tcon_reg <= tcon_next;
      led_reg  <= led_next;
      digi_reg <= digi_next;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (rd && hit) begin
      case (idx)
        3'd0:    rdata = th_reg;
        3'd1:    rdata = tl_reg;
        3'd2:    rdata = 32'(tcon_reg);
        3'd3:    rdata = 32'(led_reg);
        3'd4:    rdata = 32'(switch);
        3'd5:    rdata = 32'(digi_reg);
        default: rdata = 32'h0;
      endcase
    end
  end

  assign led    = led_reg;
  assign digi   = digi_reg;
  assign irqout = tcon_reg[1] & tcon_reg[2];

endmodule
